// File: rtl/biquad_pkg.sv
// biquad_pkg: shared coefficient indices, FSM state encoding and default data width
package biquad_pkg;
    localparam int DEF_DW   = 32;
    localparam int NUM_COEF = 6;
    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A0 = 3'd3;
    localparam logic [2:0] COEF_A1 = 3'd4;
    localparam logic [2:0] COEF_A2 = 3'd5;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
endpackage

// File: rtl/biquad_coef_sched_tick_gen.sv
// sample_tick_gen: programmable divider producing a registered one-cycle sample strobe and a strobe count
// Ports: clk/rst (async active-high), i_en run enable, i_div period-1,
//        o_stb one strobe per i_div+1 cycles, o_cnt strobes issued (wrapping)
module sample_tick_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_stb,
    output logic [CNT_W-1:0] o_cnt
);
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_stb;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    // >= rather than == so lowering i_div below the running count still terminates the period
    assign w_hit = r_div_cnt >= i_div;
    assign o_stb = r_stb;
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_stb     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_div_cnt <= (!i_en || w_hit) ? '0 : r_div_cnt + DIV_W'(1);
            r_stb     <= i_en && w_hit;
            r_cnt     <= r_cnt + CNT_W'(r_stb);
        end
    end
endmodule

// File: rtl/biquad_coef_sched.sv
// biquad_coef_sched: sample strobe sequencing plus shadow/active biquad coefficient banks with sample-aligned commit
// Ports: clk/rst (async active-high); i_en run enable; i_div divider (strobe every i_div+1 cycles);
//        i_cfg_we/i_cfg_addr/i_cfg_wdata shadow write; i_cfg_commit copy shadow to active;
//        o_cfg_busy commit pending; o_cfg_done/o_cfg_err one-cycle status pulses;
//        o_sample_stb/o_sample_cnt filter enable and strobe count; o_b0..o_a2 active coefficients
module biquad_coef_sched
    import biquad_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_cfg_we,
    input  logic [2:0]       i_cfg_addr,
    input  logic [DW-1:0]    i_cfg_wdata,
    input  logic             i_cfg_commit,
    output logic             o_cfg_busy,
    output logic             o_cfg_done,
    output logic             o_cfg_err,
    output logic             o_sample_stb,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic [DW-1:0]    o_b0,
    output logic [DW-1:0]    o_b1,
    output logic [DW-1:0]    o_b2,
    output logic [DW-1:0]    o_a0,
    output logic [DW-1:0]    o_a1,
    output logic [DW-1:0]    o_a2
);
    state_t        r_state, w_state_nxt;
    logic          r_busy, r_done, r_err;
    logic          w_stb, w_pend, w_wr_ok, w_err, w_swap;
    logic [DW-1:0] r_shadow [NUM_COEF];
    logic [DW-1:0] r_active [NUM_COEF];
    logic [DW-1:0] w_shadow_nxt [NUM_COEF];

    sample_tick_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .i_en  (i_en),
        .i_div (i_div),
        .o_stb (w_stb),
        .o_cnt (o_sample_cnt)
    );

    always_comb begin
        w_pend      = r_state == PEND;
        w_wr_ok     = i_cfg_we && (i_cfg_addr < 3'(NUM_COEF)) && !w_pend;
        w_err       = (i_cfg_we && !w_wr_ok) || (i_cfg_commit && w_pend);
        w_swap      = 1'b0;
        w_state_nxt = r_state;
        if (r_state == IDLE) begin
            w_swap      = i_cfg_commit;
            w_state_nxt = i_en ? RUN : IDLE;
        end else if (r_state == RUN) begin
            w_state_nxt = i_cfg_commit ? PEND : (i_en ? RUN : IDLE);
        end else begin
            // w_stb is the registered strobe, so this edge ends the strobe cycle: the filter
            // takes that sample with the old set and the new set applies from the next one
            w_swap      = w_stb || !i_en;
            w_state_nxt = w_swap ? (i_en ? RUN : IDLE) : PEND;
        end
        // merged view lets a write issued with a commit be included in that commit
        for (int i = 0; i < NUM_COEF; i++)
            w_shadow_nxt[i] = (w_wr_ok && i_cfg_addr == 3'(i)) ? i_cfg_wdata : r_shadow[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_swap) r_active <= w_shadow_nxt;
            r_busy   <= w_state_nxt == PEND;
            r_done   <= w_swap;
            r_err    <= w_err;
        end
    end

    assign o_cfg_busy   = r_busy;
    assign o_cfg_done   = r_done;
    assign o_cfg_err    = r_err;
    assign o_sample_stb = w_stb;
    assign o_b0         = r_active[COEF_B0];
    assign o_b1         = r_active[COEF_B1];
    assign o_b2         = r_active[COEF_B2];
    assign o_a0         = r_active[COEF_A0];
    assign o_a1         = r_active[COEF_A1];
    assign o_a2         = r_active[COEF_A2];
endmodule

// File: tb/tb_biquad_coef_sched.sv
// tb_biquad_coef_sched: scoreboard bench for strobe timing, commit sequencing and error pulses
module tb_biquad_coef_sched;
    import biquad_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, we = 1'b0, commit = 1'b0;
    logic [15:0] div = '0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, stb;
    logic [15:0] scnt;
    logic [31:0] b0, b1, b2, a0, a1, a2;
    logic [5:0][31:0] sh, act, exp_set;
    logic [5:0][31:0] exp_q[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign act = {a2, a1, a0, b2, b1, b0};

    biquad_coef_sched dut (
        .clk(clk), .rst(rst), .i_en(en), .i_div(div),
        .i_cfg_we(we), .i_cfg_addr(addr), .i_cfg_wdata(wdata), .i_cfg_commit(commit),
        .o_cfg_busy(busy), .o_cfg_done(done), .o_cfg_err(err),
        .o_sample_stb(stb), .o_sample_cnt(scnt),
        .o_b0(b0), .o_b1(b1), .o_b2(b2), .o_a0(a0), .o_a1(a1), .o_a2(a2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = stb;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = done;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if ({stb, busy, done, err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {stb, busy, done, err}); end
        n_cmp++; if (scnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", scnt); end
        n_cmp++; if (act !== '0) begin n_bad++; $display("FAIL reset_coefs: got %h want 0", act); end
        #4 rst = 1'b0;
        step();
    endtask

    task automatic test_divider();
        en = 1'b1; div = 16'd3;
        for (int c = 1; c <= 13; c++) begin
            step();
            n_cmp++; if (stb !== (c % 4 == 0)) begin n_bad++; $display("FAIL div3_stb cycle %0d: got %b want %b", c, stb, c % 4 == 0); end
        end
        n_cmp++; if (scnt !== 16'd3) begin n_bad++; $display("FAIL div3_cnt: got %0d want 3", scnt); end
        n_cmp++; if (act !== '0) begin n_bad++; $display("FAIL div3_coefs: got %h want 0", act); end
        en = 1'b0;
        step();
        step();
        n_cmp++; if (stb !== 1'b0) begin n_bad++; $display("FAIL en0_stb: got %b want 0", stb); end
    endtask

    task automatic test_idle_commit();
        we = 1'b1; addr = COEF_B0; wdata = 32'h64; sh[COEF_B0] = 32'h64;
        step();
        addr = COEF_A1; wdata = 32'h0A; sh[COEF_A1] = 32'h0A;
        step();
        we = 1'b0; commit = 1'b1; exp_q.push_back(sh);
        step();
        commit = 1'b0;
        n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL idle_done_busy: got %b want 10", {done, busy}); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL idle_coefs: got empty queue want entry"); end
        else begin exp_set = exp_q.pop_front(); if (act !== exp_set) begin n_bad++; $display("FAIL idle_coefs: got %h want %h", act, exp_set); end end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL idle_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_run_commit();
        bit ok;
        en = 1'b1; div = 16'd7;
        wait_stb(30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL run_first_stb: got timeout want strobe"); end
        we = 1'b1; addr = COEF_B2; wdata = 32'd5; sh[COEF_B2] = 32'd5;
        step();
        we = 1'b0; commit = 1'b1; exp_q.push_back(sh);
        step();
        commit = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b want 1", busy); end
        wait_stb(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL run_stb: got timeout want strobe"); end
        n_cmp++; if ({busy, b2} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL run_stb_cycle: got busy %b b2 %h want busy 1 b2 0", busy, b2); end
        step();
        n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL run_done_busy: got %b want 10", {done, busy}); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL run_coefs: got empty queue want entry"); end
        else begin exp_set = exp_q.pop_front(); if (act !== exp_set) begin n_bad++; $display("FAIL run_coefs: got %h want %h", act, exp_set); end end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL run_done_once: got %b want 0", done); end
    endtask

    task automatic test_pend_errors();
        bit ok;
        int n_done;
        wait_stb(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pend_stb: got timeout want strobe"); end
        step();
        commit = 1'b1; exp_q.push_back(sh);
        step();
        commit = 1'b0; we = 1'b1; addr = COEF_A0; wdata = 32'hDEAD;
        step();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL pend_wr_err: got %b want 1", err); end
        we = 1'b0; commit = 1'b1;
        step();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL pend_commit_err: got %b want 1", err); end
        commit = 1'b0;
        step();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL pend_err_clear: got %b want 0", err); end
        wait_done(20, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL pend_swap: got timeout or empty queue want done"); end
        else begin exp_set = exp_q.pop_front(); if (act !== exp_set) begin n_bad++; $display("FAIL pend_swap: got %h want %h", act, exp_set); end end
        n_done = 0;
        for (int i = 0; i < 12; i++) begin step(); n_done += int'(done); end
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL pend_one_swap: got %0d extra done want 0", n_done); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        wait_stb(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL same_stb: got timeout want strobe"); end
        step();
        we = 1'b1; addr = COEF_B1; wdata = 32'd9; commit = 1'b1; sh[COEF_B1] = 32'd9; exp_q.push_back(sh);
        step();
        we = 1'b0; commit = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL same_swap: got timeout or empty queue want done"); end
        else begin exp_set = exp_q.pop_front(); if (act !== exp_set) begin n_bad++; $display("FAIL same_swap: got %h want %h", act, exp_set); end end
        n_cmp++; if (b1 !== 32'd9) begin n_bad++; $display("FAIL same_b1: got %h want 9", b1); end
    endtask

    task automatic test_bad_addr();
        en = 1'b0;
        step();
        step();
        we = 1'b1; addr = 3'd6; wdata = 32'h77;
        step();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL addr6_err: got %b want 1", err); end
        we = 1'b0; commit = 1'b1; exp_q.push_back(sh);
        step();
        commit = 1'b0;
        n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL addr6_done_err: got %b want 10", {done, err}); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL addr6_coefs: got empty queue want entry"); end
        else begin exp_set = exp_q.pop_front(); if (act !== exp_set) begin n_bad++; $display("FAIL addr6_coefs: got %h want %h", act, exp_set); end end
    endtask

    task automatic test_reset_pend_wrap();
        bit ok;
        en = 1'b1; div = 16'd7;
        wait_stb(30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstp_stb: got timeout want strobe"); end
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstp_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        sh = '0;
        n_cmp++; if ({stb, busy, done, err, scnt} !== 20'h0) begin n_bad++; $display("FAIL rstp_flags: got %h want 0", {stb, busy, done, err, scnt}); end
        n_cmp++; if (act !== '0) begin n_bad++; $display("FAIL rstp_coefs: got %h want 0", act); end
        div = 16'd0;
        #3 rst = 1'b0;
        step();
        n_cmp++; if ({stb, scnt} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL div0_first: got %b/%h want 1/0000", stb, scnt); end
        step();
        n_cmp++; if ({stb, scnt} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL div0_second: got %b/%h want 1/0001", stb, scnt); end
        for (int i = 0; i < 65534; i++) step();
        n_cmp++; if (scnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_max: got %h want ffff", scnt); end
        step();
        n_cmp++; if ({stb, scnt} !== {1'b1, 16'h0}) begin n_bad++; $display("FAIL wrap_zero: got %b/%h want 1/0000", stb, scnt); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        sh = '0;
        test_reset();
        test_divider();
        test_idle_commit();
        test_run_commit();
        test_pend_errors();
        test_same_cycle();
        test_bad_addr();
        test_reset_pend_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
